// File: rtl/cpu_datapath.sv
// cpu_datapath: PC/MAR/MDR/ACC/IR registers, 2-function ALU and single-port program/data RAM.
// Define CPU_DATAPATH_CARRY_EN to add the o_acc_carry flag captured from ALU ADD into MDR.
module cpu_datapath #(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned DATA_W = OPC_W + ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_mdr,
  input  logic              i_ld_mar,
  input  logic              i_ld_pc,
  input  logic              i_ld_acc,
  input  logic              i_ld_ir,
  input  logic              i_ld_mem,
  input  logic              i_mux_ir_p1,
  input  logic              i_mux_mdr_alur,
  input  logic              i_mux_pc_ird,
  input  logic              i_alu_ctrl,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [OPC_W-1:0]  o_opcode,
  output logic              o_acc_zero,
`ifdef CPU_DATAPATH_CARRY_EN
  output logic              o_acc_carry,
`endif
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_acc
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] mdr, acc, ir, rd_q;
  logic [DATA_W-1:0] add_sum, alu_res;

  // ALU: a = ACC, b = registered RAM read data
`ifdef CPU_DATAPATH_CARRY_EN
  logic add_carry;
  logic carry_q;
  always_comb {add_carry, add_sum} = {1'b0, acc} + {1'b0, rd_q};
`else
  always_comb add_sum = acc + rd_q;
`endif

  always_comb alu_res = i_alu_ctrl ? (acc ^ rd_q) : add_sum;

  // RAM writes sit outside the reset domain; loader port wins over ACC store
  always_ff @(posedge i_clk) begin
    if (i_prog_we) begin
      mem[i_prog_addr] <= i_prog_data;
    end else if (i_ld_mem) begin
      mem[mar] <= acc;
    end
  end

  // Architectural registers; every source is a pre-edge value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc   <= '0;
      mar  <= '0;
      mdr  <= '0;
      acc  <= '0;
      ir   <= '0;
      rd_q <= '0;
    end else begin
      rd_q <= mem[mar];
      if (i_ld_pc)  pc  <= i_mux_ir_p1 ? pc + ADDR_W'(1) : ir[ADDR_W-1:0];
      if (i_ld_mar) mar <= i_mux_pc_ird ? ir[ADDR_W-1:0] : pc;
      if (i_ld_mdr) mdr <= i_mux_mdr_alur ? alu_res : rd_q;
      if (i_ld_acc) acc <= mdr;
      if (i_ld_ir)  ir  <= mdr;
    end
  end

`ifdef CPU_DATAPATH_CARRY_EN
  // Carry follows the last ALU result written into MDR; XOR clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      carry_q <= 1'b0;
    end else if (i_ld_mdr && i_mux_mdr_alur) begin
      carry_q <= i_alu_ctrl ? 1'b0 : add_carry;
    end
  end

  assign o_acc_carry = carry_q;
`endif

  assign o_opcode   = ir[DATA_W-1:ADDR_W];
  assign o_acc_zero = (acc == '0);
  assign o_pc       = pc;
  assign o_acc      = acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: strobe sequences drive the datapath, a scoreboard
// queue holds expected results that are popped when the corresponding output is sampled.
module tb_cpu_datapath;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_ld_mdr, i_ld_mar, i_ld_pc, i_ld_acc, i_ld_ir, i_ld_mem;
  logic              i_mux_ir_p1, i_mux_mdr_alur, i_mux_pc_ird, i_alu_ctrl;
  logic              i_prog_we;
  logic [ADDR_W-1:0] i_prog_addr;
  logic [DATA_W-1:0] i_prog_data;
  logic [OPC_W-1:0]  o_opcode;
  logic              o_acc_zero;
  logic [ADDR_W-1:0] o_pc;
  logic [DATA_W-1:0] o_acc;
`ifdef CPU_DATAPATH_CARRY_EN
  logic              o_acc_carry;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [ADDR_W-1:0] m_pc;

  always #5 i_clk = ~i_clk;

  cpu_datapath #(.OPC_W(OPC_W), .ADDR_W(ADDR_W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ld_mdr       (i_ld_mdr),
    .i_ld_mar       (i_ld_mar),
    .i_ld_pc        (i_ld_pc),
    .i_ld_acc       (i_ld_acc),
    .i_ld_ir        (i_ld_ir),
    .i_ld_mem       (i_ld_mem),
    .i_mux_ir_p1    (i_mux_ir_p1),
    .i_mux_mdr_alur (i_mux_mdr_alur),
    .i_mux_pc_ird   (i_mux_pc_ird),
    .i_alu_ctrl     (i_alu_ctrl),
    .i_prog_we      (i_prog_we),
    .i_prog_addr    (i_prog_addr),
    .i_prog_data    (i_prog_data),
    .o_opcode       (o_opcode),
    .o_acc_zero     (o_acc_zero),
`ifdef CPU_DATAPATH_CARRY_EN
    .o_acc_carry    (o_acc_carry),
`endif
    .o_pc           (o_pc),
    .o_acc          (o_acc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic observe(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic clr_strobes();
    i_rst = 1'b0;
    i_ld_mdr = 1'b0; i_ld_mar = 1'b0; i_ld_pc = 1'b0;
    i_ld_acc = 1'b0; i_ld_ir = 1'b0; i_ld_mem = 1'b0;
    i_mux_ir_p1 = 1'b0; i_mux_mdr_alur = 1'b0; i_mux_pc_ird = 1'b0;
    i_alu_ctrl = 1'b0; i_prog_we = 1'b0;
    i_prog_addr = '0; i_prog_data = '0;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it, then strobes drop
  task automatic tick();
    @(posedge i_clk);
    #1;
    clr_strobes();
  endtask

  task automatic prog(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i_prog_we = 1'b1; i_prog_addr = a; i_prog_data = d;
    tick();
  endtask

  // MAR already set: wait for rd_q, then load MDR from rd_q or the ALU
  task automatic mdr_fetch(input logic use_alu, input logic op);
    tick();
    i_ld_mdr = 1'b1; i_mux_mdr_alur = use_alu; i_alu_ctrl = op;
    tick();
  endtask

  // Load IR with an arbitrary word by placing it at the current PC and fetching
  task automatic set_ir(input logic [DATA_W-1:0] w);
    prog(m_pc, w);
    i_ld_mar = 1'b1; i_mux_pc_ird = 1'b0;
    tick();
    mdr_fetch(1'b0, 1'b0);
    i_ld_ir = 1'b1;
    tick();
  endtask

  task automatic set_mar_ir();
    i_ld_mar = 1'b1; i_mux_pc_ird = 1'b1;
    tick();
  endtask

  task automatic set_acc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    set_ir({4'h0, a});
    prog(a, v);
    set_mar_ir();
    mdr_fetch(1'b0, 1'b0);
    i_ld_acc = 1'b1;
    tick();
  endtask

  // ACC <= ACC op RAM[a], with RAM[a] preloaded to b
  task automatic alu_op(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] b, input logic op);
    set_ir({4'h0, a});
    prog(a, b);
    set_mar_ir();
    mdr_fetch(1'b1, op);
    i_ld_acc = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] ra, rb, rexp;
    logic [DATA_W:0]   rsum;
    logic              rop;

    clr_strobes();
    @(negedge i_clk);

    // Reset with every strobe asserted
    i_rst = 1'b1;
    i_ld_mdr = 1'b1; i_ld_mar = 1'b1; i_ld_pc = 1'b1; i_ld_acc = 1'b1;
    i_ld_ir = 1'b1; i_ld_mem = 1'b1; i_mux_ir_p1 = 1'b1; i_mux_mdr_alur = 1'b1;
    i_mux_pc_ird = 1'b1; i_alu_ctrl = 1'b1; i_prog_we = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    clr_strobes();
    m_pc = '0;
    expect_val("rst_pc", 32'h0);     observe(32'(o_pc));
    expect_val("rst_acc", 32'h0);    observe(32'(o_acc));
    expect_val("rst_opcode", 32'h0); observe(32'(o_opcode));
    expect_val("rst_zero", 32'h1);   observe(32'(o_acc_zero));
`ifdef CPU_DATAPATH_CARRY_EN
    expect_val("rst_carry", 32'h0);  observe(32'(o_acc_carry));
`endif

    // Instruction fetch from address 0
    prog(4'h0, 8'h1A);
    expect_val("fetch_opcode", 32'h1);
    i_ld_mar = 1'b1; i_mux_pc_ird = 1'b0;
    tick();
    mdr_fetch(1'b0, 1'b0);
    i_ld_ir = 1'b1;
    tick();
    observe(32'(o_opcode));
    expect_val("fetch_operand_pc", 32'hA);
    i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b0;
    tick();
    m_pc = 4'hA;
    observe(32'(o_pc));

    // ADD with wrap
    set_acc(4'h6, 8'hF0);
    expect_val("add_acc", 32'h10);
    expect_val("add_zero", 32'h0);
    alu_op(4'h5, 8'h20, 1'b0);
    observe(32'(o_acc));
    observe(32'(o_acc_zero));
`ifdef CPU_DATAPATH_CARRY_EN
    expect_val("add_carry", 32'h1);
    observe(32'(o_acc_carry));
    expect_val("carry_hold", 32'h1);
    set_acc(4'h7, 8'h5C);
    observe(32'(o_acc_carry));
`else
    set_acc(4'h7, 8'h5C);
`endif

    // XOR to zero
    expect_val("xor_acc", 32'h00);
    expect_val("xor_zero", 32'h1);
    alu_op(4'h3, 8'h5C, 1'b1);
    observe(32'(o_acc));
    observe(32'(o_acc_zero));
`ifdef CPU_DATAPATH_CARRY_EN
    expect_val("xor_carry", 32'h0);
    observe(32'(o_acc_carry));
`endif

    // PC load from IR, increment wrap, load from IR again
    set_ir(8'h0F);
    expect_val("pc_from_ir_f", 32'hF);
    i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b0;
    tick();
    m_pc = 4'hF;
    observe(32'(o_pc));
    expect_val("pc_wrap", 32'h0);
    i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b1;
    tick();
    m_pc = 4'h0;
    observe(32'(o_pc));
    set_ir(8'h37);
    expect_val("pc_from_ir_7", 32'h7);
    i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b0;
    tick();
    m_pc = 4'h7;
    observe(32'(o_pc));

    // Store ACC to RAM[2] and read it back
    set_acc(4'h9, 8'hAB);
    set_ir(8'h02);
    set_mar_ir();
    i_ld_mem = 1'b1;
    tick();
    set_mar_ir();
    expect_val("store_readback", 32'hAB);
    mdr_fetch(1'b0, 1'b0);
    i_ld_acc = 1'b1;
    tick();
    observe(32'(o_acc));

    // Loader write wins over ACC store on the same edge
    i_ld_mem = 1'b1;
    i_prog_we = 1'b1; i_prog_addr = 4'h2; i_prog_data = 8'h11;
    tick();
    expect_val("prog_priority", 32'h11);
    mdr_fetch(1'b0, 1'b0);
    i_ld_acc = 1'b1;
    tick();
    observe(32'(o_acc));

    // Simultaneous ld_pc and ld_mar: MAR takes the pre-edge PC
    prog(m_pc, 8'h9E);
    prog(m_pc + 4'(1), 8'h42);
    expect_val("parallel_pc", 32'(m_pc + 4'(1)));
    expect_val("parallel_opcode", 32'h9);
    i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b1;
    i_ld_mar = 1'b1; i_mux_pc_ird = 1'b0;
    tick();
    m_pc = m_pc + 4'(1);
    observe(32'(o_pc));
    mdr_fetch(1'b0, 1'b0);
    i_ld_ir = 1'b1;
    tick();
    observe(32'(o_opcode));

    // ALU sweep: first entry is the all-ones carry boundary, rest random
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        ra = 8'hFF; rb = 8'h01; rop = 1'b0;
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rop = 1'($urandom_range(0, 1));
      end
      rsum = {1'b0, ra} + {1'b0, rb};
      rexp = rop ? (ra ^ rb) : rsum[DATA_W-1:0];
      set_acc(4'h6, ra);
      expect_val("sweep_acc", 32'(rexp));
      expect_val("sweep_zero", 32'(rexp == 8'h00));
`ifdef CPU_DATAPATH_CARRY_EN
      expect_val("sweep_carry", rop ? 32'h0 : 32'(rsum[DATA_W]));
`endif
      alu_op(4'h5, rb, rop);
      observe(32'(o_acc));
      observe(32'(o_acc_zero));
`ifdef CPU_DATAPATH_CARRY_EN
      observe(32'(o_acc_carry));
`endif
    end

    // Reset mid-operation: registers clear, coinciding RAM store still lands
    set_acc(4'h4, 8'hC3);
    set_ir(8'h00);
    set_mar_ir();
    i_rst = 1'b1;
    i_ld_mem = 1'b1; i_ld_pc = 1'b1; i_mux_ir_p1 = 1'b1;
    i_ld_acc = 1'b1; i_ld_ir = 1'b1; i_ld_mdr = 1'b1; i_ld_mar = 1'b1;
    tick();
    m_pc = '0;
    expect_val("midrst_pc", 32'h0);     observe(32'(o_pc));
    expect_val("midrst_acc", 32'h0);    observe(32'(o_acc));
    expect_val("midrst_zero", 32'h1);   observe(32'(o_acc_zero));
    expect_val("midrst_opcode", 32'h0); observe(32'(o_opcode));
    expect_val("midrst_store", 32'hC3);
    i_ld_mar = 1'b1; i_mux_pc_ird = 1'b0;
    tick();
    mdr_fetch(1'b0, 1'b0);
    i_ld_acc = 1'b1;
    tick();
    observe(32'(o_acc));

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
